// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Shares the single pipelined memory read port between the I-cache and
//   D-cache miss handlers. Each grant runs one complete block fill: it issues
//   BLOCK_WORDS word reads, steers the returned words into the owner's data
//   array, then pulses the owner's tag write and done strobe.
//
//   Optional feature macro: FILL_CRITICAL_FIRST_EN
//     defined   -> the fill starts at the missing word and wraps around the block
//     undefined -> the fill always runs word 0..BLOCK_WORDS-1
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   icache_miss/_addr             I-cache fill request and byte address
//   dcache_miss/_addr             D-cache fill request and byte address
//   mem_en, mem_addr              memory read request (one word per cycle)
//   mem_data_valid, mem_data      in-order read returns
//   fill_sel                      fill owner (0 = I-cache, 1 = D-cache)
//   fill_data, fill_word,
//   fill_data_wen                 data-array write to the owner
//   fill_tag_wen                  tag/valid write to the owner
//   icache_fill_done,
//   dcache_fill_done              one-cycle fill-complete pulses
//   busy                          a fill is in progress
module mem_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           icache_miss,
  input  logic [ADDR_W-1:0]              icache_miss_addr,
  input  logic                           dcache_miss,
  input  logic [ADDR_W-1:0]              dcache_miss_addr,
  output logic                           mem_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_data_valid,
  input  logic [DATA_W-1:0]              mem_data,
  output logic                           fill_sel,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           fill_data_wen,
  output logic                           fill_tag_wen,
  output logic                           icache_fill_done,
  output logic                           dcache_fill_done,
  output logic                           busy
);

  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = WORD_W + 1;          // byte-offset bits of a block
  localparam int CNT_W  = WORD_W + 1;          // counters must reach BLOCK_WORDS
  localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_r;
  logic [CNT_W-1:0]         issue_cnt_r;
  logic [CNT_W-1:0]         recv_cnt_r;
  logic                     last_grant_r;     // 1 = D-cache was granted last
  logic [ADDR_W-OFF_W-1:0]  base_hi_r;        // block address (offset bits implied zero)
  logic [WORD_W-1:0]        w0_r;             // first word of the fill order
  logic                     fill_sel_r;
  logic                     mem_en_r;
  logic [ADDR_W-1:0]        mem_addr_r;
  logic                     tag_wen_r;
  logic                     idone_r;
  logic                     ddone_r;
  logic                     busy_r;

  logic                     grant_any_s;
  logic                     grant_d_s;
  logic [ADDR_W-OFF_W-1:0]  new_base_hi_s;
  logic [WORD_W-1:0]        new_w0_s;
  logic                     accept_s;
  logic                     recv_full_s;
  logic [WORD_W-1:0]        next_word_s;

  // On a tie the requester that was not served last wins; the reset value
  // of last_grant_r (I-cache) hands the first tie to the D-cache.
  assign grant_any_s   = icache_miss | dcache_miss;
  assign grant_d_s     = dcache_miss & (~icache_miss | ~last_grant_r);
  assign new_base_hi_s = grant_d_s ? dcache_miss_addr[ADDR_W-1:OFF_W]
                                   : icache_miss_addr[ADDR_W-1:OFF_W];
`ifdef FILL_CRITICAL_FIRST_EN
  assign new_w0_s = grant_d_s ? dcache_miss_addr[OFF_W-1:1]
                              : icache_miss_addr[OFF_W-1:1];
`else
  assign new_w0_s = {WORD_W{1'b0}};
`endif

  // Returns are accepted only while a fill is open and the block is not yet full.
  assign accept_s    = ((state_r == REQ) || (state_r == DRAIN)) && mem_data_valid &&
                       (recv_cnt_r < BLK_CNT);
  // Block complete, counting a word that arrives this cycle.
  assign recv_full_s = (recv_cnt_r == BLK_CNT) || (accept_s && (recv_cnt_r == BLK_LAST));
  // Word index of the request after the current one; WORD_W wrap gives the modulo.
  assign next_word_s = w0_r + issue_cnt_r[WORD_W-1:0] + WORD_W'(1);

  // Fill sequencer: state, counters, captured request and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      issue_cnt_r  <= {CNT_W{1'b0}};
      recv_cnt_r   <= {CNT_W{1'b0}};
      last_grant_r <= 1'b0;
      base_hi_r    <= {(ADDR_W-OFF_W){1'b0}};
      w0_r         <= {WORD_W{1'b0}};
      fill_sel_r   <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      tag_wen_r    <= 1'b0;
      idone_r      <= 1'b0;
      ddone_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      tag_wen_r <= 1'b0;
      idone_r   <= 1'b0;
      ddone_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            state_r      <= REQ;
            base_hi_r    <= new_base_hi_s;
            w0_r         <= new_w0_s;
            fill_sel_r   <= grant_d_s;
            last_grant_r <= grant_d_s;
            issue_cnt_r  <= {CNT_W{1'b0}};
            recv_cnt_r   <= {CNT_W{1'b0}};
            mem_en_r     <= 1'b1;
            mem_addr_r   <= {new_base_hi_s, new_w0_s, 1'b0};
            busy_r       <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          issue_cnt_r <= issue_cnt_r + CNT_W'(1);
          if (accept_s) begin
            recv_cnt_r <= recv_cnt_r + CNT_W'(1);
          end
          if (issue_cnt_r == BLK_LAST) begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            if (recv_full_s) begin
              state_r   <= DONE;
              tag_wen_r <= 1'b1;
              idone_r   <= ~fill_sel_r;
              ddone_r   <= fill_sel_r;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            mem_addr_r <= {base_hi_r, next_word_s, 1'b0};
          end
        end
        DRAIN: begin
          if (accept_s) begin
            recv_cnt_r <= recv_cnt_r + CNT_W'(1);
          end
          if (recv_full_s) begin
            state_r   <= DONE;
            tag_wen_r <= 1'b1;
            idone_r   <= ~fill_sel_r;
            ddone_r   <= fill_sel_r;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          mem_en_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Return path: memory words pass straight through to the owner's data array.
  always_comb begin
    fill_data_wen = 1'b0;
    fill_data     = {DATA_W{1'b0}};
    fill_word     = {WORD_W{1'b0}};
    if (accept_s) begin
      fill_data_wen = 1'b1;
      fill_data     = mem_data;
      fill_word     = w0_r + recv_cnt_r[WORD_W-1:0];
    end else begin
      fill_data_wen = 1'b0;
    end
  end

  assign mem_en           = mem_en_r;
  assign mem_addr         = mem_addr_r;
  assign fill_sel         = fill_sel_r;
  assign fill_tag_wen     = tag_wen_r;
  assign icache_fill_done = idone_r;
  assign dcache_fill_done = ddone_r;
  assign busy             = busy_r;

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single pipelined main-memory read port between the I-cache and D-cache miss handlers.
- Sequences one full cache-block fill per grant: issues the word reads, steers the returned words into the owning cache's data array, then writes the tag.
- Sits between the two cache controllers and the memory model. It is the only master of the memory read port during fills.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, memory word width in bits.
- BLOCK_WORDS, 8, words per cache block. Must be a power of 2. Block size in bytes is 2*BLOCK_WORDS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- icache_miss  in  1  I-cache requests a fill. Held high until icache_fill_done.
- icache_miss_addr  in  ADDR_W  byte address of the I-cache miss.
- dcache_miss  in  1  D-cache requests a fill. Held high until dcache_fill_done.
- dcache_miss_addr  in  ADDR_W  byte address of the D-cache miss.
- mem_en  out  1  read request to memory, one word per cycle.
- mem_addr  out  ADDR_W  byte address of the current read request.
- mem_data_valid  in  1  memory returns a word this cycle, in request order.
- mem_data  in  DATA_W  returned word.
- fill_sel  out  1  fill owner: 0 = I-cache, 1 = D-cache.
- fill_data  out  DATA_W  word to write into the owner's data array (mem_data passed through).
- fill_word  out  log2(BLOCK_WORDS)  word offset within the block for fill_data.
- fill_data_wen  out  1  data-array write enable for the owner.
- fill_tag_wen  out  1  tag/valid write enable for the owner.
- icache_fill_done  out  1  one-cycle pulse: I-cache fill complete.
- dcache_fill_done  out  1  one-cycle pulse: D-cache fill complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; issue_cnt = recv_cnt = 0; last_grant = I; captured base address = 0; fill_sel = 0.
  - All outputs are 0.
  - A reset mid-fill abandons the fill. No done pulse is produced.
- States: IDLE, REQ, DRAIN, DONE.
- IDLE:
  - Only dcache_miss high: grant D. Only icache_miss high: grant I.
  - Both high: grant the requester that is not last_grant (round-robin). The first tie after reset goes to D.
  - On grant: capture base = miss_addr with the low log2(2*BLOCK_WORDS) bits cleared; set fill_sel; set last_grant; clear both counters; go to REQ.
  - mem_data_valid is ignored in IDLE.
- REQ:
  - mem_en = 1 and mem_addr = base + 2*issue_cnt each cycle; issue_cnt increments every cycle.
  - After BLOCK_WORDS requests (BLOCK_WORDS cycles), go to DRAIN. If recv_cnt is already complete, go straight to DONE.
- Returns (REQ and DRAIN):
  - On each mem_data_valid with recv_cnt < BLOCK_WORDS: fill_data_wen = 1, fill_data = mem_data, fill_word = recv_cnt, then recv_cnt increments.
  - Extra valids beyond BLOCK_WORDS are ignored.
  - Issue and return may occur in the same cycle.
- DRAIN: mem_en = 0. When recv_cnt reaches BLOCK_WORDS (counting a return in the current cycle), go to DONE on the next edge.
- DONE (exactly one cycle):
  - fill_tag_wen = 1, and the owner's done pulse is high. Then go to IDLE.
  - The requester must deassert its miss in the cycle after done. The miss line is re-sampled in IDLE, and a new grant takes one IDLE cycle at minimum.
- Misses are not re-checked during a fill. A miss that drops mid-fill does not abort the fill; the fill runs to completion.
- fill_data_wen, fill_tag_wen and mem_en are never asserted in IDLE.
- Latency: miss first high in cycle 0 (IDLE) → REQ in cycles 1..BLOCK_WORDS. With a fixed memory latency L, done is asserted in cycle BLOCK_WORDS+L+1.

Optional Feature:
- Macro: FILL_CRITICAL_FIRST_EN.
- Defined: issue order starts at the miss word offset w0 = miss_addr[log2(2*BLOCK_WORDS)-1:1] and wraps modulo BLOCK_WORDS.
  - mem_addr = base + 2*((w0+issue_cnt) mod BLOCK_WORDS).
  - fill_word = (w0+recv_cnt) mod BLOCK_WORDS.
- Not defined: word order is always 0..BLOCK_WORDS-1. The offset bits of the miss address are ignored.

Test Plan (memory latency 4 unless noted; BLOCK_WORDS 8):
- D miss only, dcache_miss_addr=0x1234 → mem_addr 0x1230,0x1232,…,0x123E in cycles 1-8; fill_data_wen in cycles 5-12 with fill_word 0..7 and fill_sel=1; fill_tag_wen and dcache_fill_done in cycle 13; busy low in cycle 14.
- icache_miss and dcache_miss both high from reset → D granted first. I is granted in the IDLE cycle after dcache_fill_done (fill_sel=0), and the I fill is done 13 cycles after that grant cycle.
- Three back-to-back tie cases with both misses re-asserted → grants alternate D, I, D.
- Memory returns 10 valids for one fill → exactly 8 fill_data_wen pulses; extras produce no writes; exactly one done pulse.
- rst pulled low in cycle 6 of a fill → all outputs 0 immediately. After release, in-flight valids cause no writes and no done pulse occurs.
- FILL_CRITICAL_FIRST_EN defined, dcache_miss_addr=0x100A → mem_addr order 0x100A,0x100C,0x100E,0x1000,…,0x1008; fill_word order 5,6,7,0,1,2,3,4.
